// File: rtl/phys_free_list_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// phys_free_list_ctrl_pkg
//   Core-wide rename parameters shared by the RAT, ROB, decode and the
//   physical-register free list, plus the free-list pointer type.
//   PRF_DEPTH  physical registers
//   ARF_DEPTH  architectural registers (permanently mapped at any time)
//   ID_WIDTH   allocation lanes (decode width)
//   CMT_WIDTH  release lanes (commit width)
// ---------------------------------------------------------------------------
package phys_free_list_ctrl_pkg;

    localparam int PRF_DEPTH = 64;
    localparam int ARF_DEPTH = 32;
    localparam int ID_WIDTH  = 2;
    localparam int CMT_WIDTH = 2;
    localparam int PRF_IDX   = $clog2(PRF_DEPTH);

    // Free-list capacity: every physical register not holding a committed
    // architectural value. Must be a power of two so the pointers wrap cleanly.
    localparam int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
    localparam int FL_IDX    = $clog2(FL_DEPTH);

    typedef logic [PRF_IDX-1:0] prf_idx_t;

    // Wrap bit in the MSB, slot index below it. Distance between two pointers
    // is plain modular subtraction, which distinguishes full from empty.
    typedef logic [FL_IDX:0]    fl_ptr_t;

    function automatic logic [FL_IDX-1:0] ptr_slot(input fl_ptr_t p);
        return p[FL_IDX-1:0];
    endfunction

endpackage

// File: rtl/phys_free_list_ctrl_prefix_popcount.sv
// ---------------------------------------------------------------------------
// phys_free_list_ctrl_prefix_popcount
//   Exclusive prefix population count over a lane-valid vector. Lane i gets
//   the number of set bits strictly below it, which is its compacted slot
//   offset; total is the number of set bits overall.
//   vec     in   [N]        lane valid bits
//   prefix  out  [N][CW]    set bits in vec[i-1:0] (lane 0 always 0)
//   total   out  [CW]       set bits in vec
// ---------------------------------------------------------------------------
module phys_free_list_ctrl_prefix_popcount #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         vec,
    output logic [N-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] run;

    // NOTE: every variable written in a combinational block gets a default
    // before any conditional logic, otherwise a latch is inferred.
    always_comb begin
        run    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = run;
            run       = run + CW'(vec[i]);
        end
        total = run;
    end

endmodule

// File: rtl/phys_free_list_ctrl.sv
// ---------------------------------------------------------------------------
// phys_free_list_ctrl
//   Free list of physical register indices for register renaming. One
//   circular buffer with three pointers:
//     spec_head  next index handed to rename (speculative)
//     ret_head   oldest allocation not yet retired
//     tail       next slot to receive a released index
//   A flush copies ret_head into spec_head, returning every speculative
//   allocation in a single cycle.
//
//   clk          in   1                       clock
//   rst_n        in   1                       synchronous active-low reset
//   alloc_valid  in   [ID_WIDTH]              lane i takes one index this cycle
//   alloc_ready  out  1                       at least ID_WIDTH indices free
//   free_idx     out  [ID_WIDTH][PRF_IDX]     index offered to lane i
//   cmt_valid    in   [CMT_WIDTH]             lane j retired a register write
//   cmt_old_phy  in   [CMT_WIDTH][PRF_IDX]    stale mapping released by lane j
//   flush        in   1                       discard speculative allocations
//   spec_count   out  [PRF_IDX+1]             indices between spec_head and tail
// ---------------------------------------------------------------------------
module phys_free_list_ctrl
    import phys_free_list_ctrl_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ID_WIDTH-1:0]                alloc_valid,
    output logic                               alloc_ready,
    output logic [ID_WIDTH-1:0][PRF_IDX-1:0]   free_idx,
    input  logic [CMT_WIDTH-1:0]               cmt_valid,
    input  logic [CMT_WIDTH-1:0][PRF_IDX-1:0]  cmt_old_phy,
    input  logic                               flush,
    output logic [PRF_IDX:0]                   spec_count
);

    localparam int ACW = $clog2(ID_WIDTH + 1);
    localparam int CCW = $clog2(CMT_WIDTH + 1);

    prf_idx_t entries [FL_DEPTH];
    fl_ptr_t  spec_head;
    fl_ptr_t  ret_head;
    fl_ptr_t  tail;

    fl_ptr_t  spec_head_next;
    fl_ptr_t  ret_head_next;
    fl_ptr_t  tail_next;

    fl_ptr_t  spec_used;   // tail - spec_head: indices still offerable
    fl_ptr_t  ret_used;    // tail - ret_head: free plus in-flight indices
    fl_ptr_t  spec_out;    // spec_head - ret_head: allocated, not yet retired
    logic     pop_en;

    logic [ID_WIDTH-1:0][ACW-1:0]  alloc_pfx;
    logic [ACW-1:0]                alloc_total;
    logic [CMT_WIDTH-1:0][CCW-1:0] cmt_pfx;
    logic [CCW-1:0]                cmt_total;

    phys_free_list_ctrl_prefix_popcount #(.N(ID_WIDTH), .CW(ACW)) u_alloc_cnt (
        .vec    (alloc_valid),
        .prefix (alloc_pfx),
        .total  (alloc_total)
    );

    phys_free_list_ctrl_prefix_popcount #(.N(CMT_WIDTH), .CW(CCW)) u_cmt_cnt (
        .vec    (cmt_valid),
        .prefix (cmt_pfx),
        .total  (cmt_total)
    );

    assign spec_used  = tail - spec_head;
    assign ret_used   = tail - ret_head;
    assign spec_out   = spec_head - ret_head;
    assign spec_count = (PRF_IDX + 1)'(spec_used);

    // Ready looks only at state and flush, never at alloc_valid, so rename can
    // use it to form alloc_valid without a combinational loop.
    assign alloc_ready = rst_n && !flush && (spec_used >= fl_ptr_t'(ID_WIDTH));
    assign pop_en      = alloc_ready;

    // Lanes are compacted: each lane reads the slot after those taken by the
    // active lanes below it, so an idle lane does not burn an index.
    always_comb begin
        free_idx = '0;
        if (rst_n) begin
            for (int i = 0; i < ID_WIDTH; i++) begin
                free_idx[i] = entries[ptr_slot(spec_head + fl_ptr_t'(alloc_pfx[i]))];
            end
        end
    end

    // Each retired register write returns one stale index and retires one
    // allocation, so tail and ret_head advance together.
    always_comb begin
        tail_next      = tail + fl_ptr_t'(cmt_total);
        ret_head_next  = ret_head + fl_ptr_t'(cmt_total);
        spec_head_next = spec_head;
        if (flush) begin
            // Commits in the flush cycle are real, so restore to the updated head.
            spec_head_next = ret_head_next;
        end else if (pop_en) begin
            spec_head_next = spec_head + fl_ptr_t'(alloc_total);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_head <= '0;
            ret_head  <= '0;
            tail      <= fl_ptr_t'(FL_DEPTH);
            // NOTE: the buffer contents are architectural state here (the
            // initial pool of unmapped registers), so the storage is reset
            // rather than left undefined as a plain memory would be.
            for (int k = 0; k < FL_DEPTH; k++) begin
                entries[k] <= prf_idx_t'(ARF_DEPTH + k);
            end
        end else begin
            spec_head <= spec_head_next;
            ret_head  <= ret_head_next;
            tail      <= tail_next;
            // Release slots sit behind ret_head, disjoint from the slots being
            // offered, so a same-cycle pop always reads the pre-edge value.
            for (int j = 0; j < CMT_WIDTH; j++) begin
                if (cmt_valid[j]) begin
                    entries[ptr_slot(tail + fl_ptr_t'(cmt_pfx[j]))] <= cmt_old_phy[j];
                end
            end
        end
    end

    // Rename must not take indices while the list cannot supply them.
    a_alloc_only_when_ready : assert property (
        @(posedge clk) disable iff (!rst_n)
        flush || alloc_ready || (alloc_valid == '0)
    );

    a_never_overfull : assert property (
        @(posedge clk) disable iff (!rst_n)
        ret_used <= fl_ptr_t'(FL_DEPTH)
    );

    a_spec_head_in_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        spec_out <= ret_used
    );

    // A release needs a matching outstanding allocation, otherwise the
    // list would hold more indices than its capacity.
    a_push_within_capacity : assert property (
        @(posedge clk) disable iff (!rst_n)
        fl_ptr_t'(cmt_total) <= spec_out
    );

    for (genvar j = 0; j < CMT_WIDTH; j++) begin : g_old_phy_chk
        // p0 is the hard-wired zero register and is never renamed.
        a_old_phy_nonzero : assert property (
            @(posedge clk) disable iff (!rst_n)
            cmt_valid[j] |-> (cmt_old_phy[j] != '0)
        );
    end

endmodule
